// File: rtl/load_store_unit.sv
// Byte-serial RV32I load/store unit: one data-memory byte per ACCESS cycle, little-endian.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/HU/W ops into error responses.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [31:0]       mem_wr_data,
    output logic              mem_sw,
    input  logic [31:0]       mem_rd_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state;
    logic              op_we;
    logic [2:0]        op_funct3;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [1:0]        beat;
    logic [31:0]       load_data;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              op_legal;
    logic [1:0]        last_beat;
    logic [ADDR_W-1:0] beat_addr;
    logic [31:0]       load_next;
    logic [31:0]       load_ext;
    logic              unused_rd_bits;

    assign unused_rd_bits = ^mem_rd_data[31:8];

    always_comb begin
        case (req_funct3)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
            3'b100, 3'b101:         op_legal = !req_we;
            default:                op_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            op_legal = 1'b0;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            op_legal = 1'b0;
`endif
    end

    always_comb begin
        case (op_funct3[1:0])
            2'b00:   last_beat = 2'd0;
            2'b01:   last_beat = 2'd1;
            default: last_beat = 2'd3;
        endcase
    end

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign beat_addr   = op_addr + ADDR_W'(beat);
    assign mem_wr_addr = beat_addr;
    assign mem_rd_addr = beat_addr;
    assign mem_wr_data = {24'h0, op_wdata[{beat, 3'b000} +: 8]};
    assign mem_sw      = (state == ST_ACCESS) && op_we;

    // Final byte is merged combinationally so the response is ready on the last beat's edge.
    always_comb begin
        load_next = load_data;
        load_next[{beat, 3'b000} +: 8] = mem_rd_data[7:0];
    end

    always_comb begin
        case (op_funct3)
            3'b000:  load_ext = {{24{load_next[7]}}, load_next[7:0]};
            3'b001:  load_ext = {{16{load_next[15]}}, load_next[15:0]};
            3'b100:  load_ext = {24'h0, load_next[7:0]};
            3'b101:  load_ext = {16'h0, load_next[15:0]};
            default: load_ext = load_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_we        <= 1'b0;
            op_funct3    <= '0;
            op_addr      <= '0;
            op_wdata     <= '0;
            beat         <= '0;
            load_data    <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_we     <= req_we;
                        op_funct3 <= req_funct3;
                        op_addr   <= req_addr;
                        op_wdata  <= req_wdata;
                        beat      <= '0;
                        load_data <= '0;
                        if (op_legal) begin
                            state <= ST_ACCESS;
                        end else begin
                            state        <= ST_RESP;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    load_data <= load_next;
                    if (beat == last_beat) begin
                        state        <= ST_RESP;
                        beat         <= '0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= op_we ? 32'h0 : load_ext;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte memory model, directed cases, then random ops
// checked against a word-level reference of memory contents and RV32I load semantics.
module tb_load_store_unit;

    localparam int AW    = 5;
    localparam int MEM_N = 1 << AW;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_wr_addr;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_wr_data;
    logic          mem_sw;
    logic [31:0]   mem_rd_data;

    logic [7:0] mem     [MEM_N];
    logic [7:0] ref_mem [MEM_N];
    logic       mem_init;

    int n_checks;
    int n_fail;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wr_addr(mem_wr_addr),
        .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data),
        .mem_sw     (mem_sw),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upper read bits carry junk; the unit must only use bits [7:0].
    assign mem_rd_data = {8'hA5, 8'h3C, 8'h96, mem[mem_rd_addr]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= 8'(i);
        end else if (mem_sw) begin
            mem[mem_wr_addr] <= mem_wr_data[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_legal(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr);
        bit ok;
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (we && f3 >= 3'd4) ok = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (size_bytes(f3) == 2 && (addr % 2) != 0) ok = 0;
        if (size_bytes(f3) == 4 && (addr % 4) != 0) ok = 0;
`else
        if (addr > 0) ok = ok;
`endif
        return ok;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [AW-1:0] addr);
        longint unsigned raw;
        int n;
        n = size_bytes(f3);
        raw = 0;
        for (int k = 0; k < n; k++)
            raw += longint'(ref_mem[(int'(addr) + k) % MEM_N]) << (8 * k);
        if (f3 == 3'd0 && raw >= 128)   raw = raw + 64'hFFFF_FF00;
        if (f3 == 3'd1 && raw >= 32768) raw = raw + 64'hFFFF_0000;
        return raw[31:0];
    endfunction

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input int hold);
        bit          ok;
        int          n;
        int          cyc;
        int          sw_cnt;
        logic [31:0] exp_data;
        logic [31:0] snap_d;
        logic        snap_e;

        ok       = is_legal(we, f3, addr);
        n        = size_bytes(f3);
        exp_data = (ok && !we) ? model_load(f3, addr) : 32'h0;
        if (ok && we)
            for (int k = 0; k < n; k++)
                ref_mem[(int'(addr) + k) % MEM_N] = 8'((wdata >> (8 * k)) & 32'hFF);

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = AW'($urandom);
        req_wdata  = $urandom;

        cyc = 1;
        sw_cnt = 0;
        while (!resp_valid && cyc <= 8) begin
            check("addr_tie", 32'(mem_rd_addr), 32'(mem_wr_addr));
            if (ok) check("beat_addr", 32'(mem_rd_addr), 32'((int'(addr) + cyc - 1) % MEM_N));
            if (mem_sw) begin
                sw_cnt++;
                check("wr_data", mem_wr_data, (wdata >> (8 * (cyc - 1))) & 32'hFF);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("latency", 32'(cyc), ok ? 32'(n + 1) : 32'd1);
        check("sw_count", 32'(sw_cnt), (ok && we) ? 32'(n) : 32'd0);
        check("rdata", resp_rdata, exp_data);
        check("err", 32'(resp_err), ok ? 32'd0 : 32'd1);

        snap_d = resp_rdata;
        snap_e = resp_err;
        for (int i = 0; i < hold; i++) begin
            check("req_ready_resp", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, snap_d);
            check("hold_err", 32'(resp_err), 32'(snap_e));
            check("hold_sw", 32'(mem_sw), 32'd0);
        end
        check("req_ready_hs", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_valid_after", 32'(resp_valid), 32'd0);
        check("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mem_init   = 1'b1;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = 8'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_sw", 32'(mem_sw), 32'd0);
        check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
        check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        rst      = 1'b0;
        mem_init = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 3'b010, 5'd4, 32'h0, 0);          // LW 4 -> 0x07060504
        run_op(1'b0, 3'b001, 5'd2, 32'h0, 3);          // LH 2 held 3 cycles
        run_op(1'b0, 3'b010, 5'd30, 32'h0, 1);         // LW 30 wraps or traps
        run_op(1'b1, 3'b000, 5'd3, 32'h0000_0080, 0);  // SB 3
        run_op(1'b0, 3'b000, 5'd3, 32'h0, 0);          // LB 3
        run_op(1'b0, 3'b100, 5'd3, 32'h0, 2);          // LBU 3
        run_op(1'b1, 3'b100, 5'd5, 32'h1234_5678, 0);  // illegal store size
        run_op(1'b0, 3'b111, 5'd0, 32'h0, 1);          // illegal funct3

        // Reset in the middle of SW 8: two bytes land, the rest are dropped.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 5'd8;
        req_wdata  = 32'hAABB_CCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid_beat0_sw", 32'(mem_sw), 32'd1);
        @(posedge clk); #1;
        check("rstmid_beat1_sw", 32'(mem_sw), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_sw", 32'(mem_sw), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        check("rstmid_wr_addr", 32'(mem_wr_addr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("rstmid_no_resp", 32'(resp_valid), 32'd0);
            check("rstmid_no_sw", 32'(mem_sw), 32'd0);
            @(posedge clk); #1;
        end
        check("rstmid_mem8", 32'(mem[8]), 32'hDD);
        check("rstmid_mem9", 32'(mem[9]), 32'hCC);
        check("rstmid_mem10", 32'(mem[10]), 32'd10);
        check("rstmid_mem11", 32'(mem[11]), 32'd11);
        ref_mem[8] = 8'hDD;
        ref_mem[9] = 8'hCC;

        for (int t = 0; t < 60; t++) begin
            run_op(1'($urandom), 3'($urandom_range(0, 7)), AW'($urandom),
                   $urandom, int'($urandom_range(0, 3)));
        end

        for (int a = 0; a < MEM_N; a += 4)
            run_op(1'b0, 3'b010, AW'(a), 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 5, data-memory byte-address width; address arithmetic wraps modulo 2**ADDR_W.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  execute stage offers a memory op.
REQ-005 req_ready  output  1  unit can accept an op; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  ADDR_W  byte address of the first byte.
REQ-009 req_wdata  input  32  store data; low bytes used per size.
REQ-010 resp_valid  output  1  op complete; held until resp_ready.
REQ-011 resp_ready  input  1  consumer accepts the response.
REQ-012 resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-013 resp_err  output  1  op rejected; no memory side effect.
REQ-014 mem_wr_addr, mem_rd_addr  output  ADDR_W each  byte address to the data memory.
REQ-015 mem_wr_data  output  32  store byte in bits [7:0], bits [31:8] zero.
REQ-016 mem_sw  output  1  byte write enable to the data memory.
REQ-017 mem_rd_data  input  32  combinational read data; only bits [7:0] used.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on req_valid&&req_ready with a legal op; IDLE->RESP directly for an illegal op; ACCESS->RESP after the last beat; RESP->IDLE on resp_ready.
REQ-019 Request fields are registered on acceptance; later input changes do not affect the op in flight.
REQ-020 Beat count N = 1 (B/BU), 2 (H/HU), 4 (W); one byte per ACCESS cycle, little-endian, beat k uses address (req_addr+k) mod 2**ADDR_W.
REQ-021 Store beat k: mem_sw=1, mem_wr_addr=addr+k, mem_wr_data={24'b0, wdata byte k}; mem_sw=0 in every other cycle.
REQ-022 Load beat k: mem_rd_addr=addr+k; mem_rd_data[7:0] captured into result byte k at that posedge.
REQ-023 mem_* outputs are combinational from registered state; mem_rd_addr=mem_wr_addr in all cycles.
REQ-024 Latency: accept at edge 0, beats on cycles 1..N, resp_valid high from cycle N+1; illegal op gives resp_valid in cycle 1.
REQ-025 B/H loads sign-extend from bit 7/15; BU/HU zero-extend; W unmodified.
REQ-026 funct3 011, 110, 111, or funct3 1xx with req_we=1, is illegal: resp_err=1, no memory access.
REQ-027 resp_valid, resp_rdata and resp_err stay stable while resp_valid=1 and resp_ready=0.
REQ-028 No new request is accepted in the cycle a response is consumed; req_ready rises the following cycle.

Reset
REQ-029 On rst at posedge: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_sw=0, mem addresses 0, beat counter 0.
REQ-030 Reset mid-ACCESS abandons the op: bytes already written remain, no further mem_sw, no response produced.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]!=0, or W with addr[1:0]!=0, is illegal per REQ-026.
REQ-032 Macro undefined: misaligned ops execute byte-wise per REQ-020, including wrap past address 2**ADDR_W-1.

Verification
REQ-033 After reset (mem[i]=i), LW addr 4 -> resp_rdata 0x07060504 in cycle 5, resp_err 0.
REQ-034 SB addr 3 wdata 0x00000080, then LB 3 -> 0xFFFFFF80; LBU 3 -> 0x00000080; exactly one mem_sw pulse on the store.
REQ-035 Macro undefined: LW addr 30 -> 0x01001F1E; macro defined: same op -> resp_err 1, rdata 0, no beats.
REQ-036 SW addr 8 wdata 0xAABBCCDD, rst asserted after 2 beats -> mem[8]=0xDD, mem[9]=0xCC, mem[10]/[11] untouched, resp_valid stays 0.
REQ-037 LH addr 2 with resp_ready held low 3 cycles -> response 0x00000302 stable all 3 cycles; req_ready 0 until the cycle after the handshake.
REQ-038 req_we=1 funct3 100 -> resp_err 1 in cycle 1, mem_sw never asserted.
